// File: rtl/antirrebote_boton.sv
// rtl/antirrebote_boton.sv - push-button synchroniser and bounce filter with a clean registered level output
module antirrebote_boton #(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic button_i,
  output logic button_o
);

  typedef enum logic [1:0] {
    BAJO        = 2'd0,
    ESPERA_ALTO = 2'd1,
    ALTO        = 2'd2,
    ESPERA_BAJO = 2'd3
  } state_t;

  // Terminal count: a new level must be seen on this many further cycles after the first one
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             out_next;

  // Two-flop synchroniser; only sync_q2 is ever looked at by the filter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= button_i;
      sync_q2 <= sync_q1;
    end
  end

  // State, stability counter and output register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BAJO;
      cnt      <= '0;
      button_o <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      button_o <= out_next;
    end
  end

  // Next state and counter; the counter restarts on every reversal so a glitch never accumulates
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    case (state)
      BAJO: begin
        if (sync_q2) begin
          state_next = ESPERA_ALTO;
        end
      end
      ESPERA_ALTO: begin
        if (!sync_q2) begin
          state_next = BAJO;
        end else if (cnt == CNT_MAX) begin
          state_next = ALTO;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ALTO: begin
        if (!sync_q2) begin
          state_next = ESPERA_BAJO;
        end
      end
      ESPERA_BAJO: begin
        if (sync_q2) begin
          state_next = ALTO;
        end else if (cnt == CNT_MAX) begin
          state_next = BAJO;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = BAJO;
      end
    endcase
  end

  // Moore output decoded from the next state so button_o is a flop with no path from button_i
  always_comb begin
    out_next = 1'b0;
    if (state_next == ALTO || state_next == ESPERA_BAJO) begin
      out_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_antirrebote_boton.sv
// tb/tb_antirrebote_boton.sv - scoreboard bench for antirrebote_boton with a window-based reference model
module tb_antirrebote_boton;

  localparam int STABLE = 4;
  localparam int LAT    = STABLE + 3;

  logic clk;
  logic rst;
  logic button_i;
  logic button_o;

  int   checks   = 0;
  int   failures = 0;

  logic exp_q[$];

  // reference model: two-cycle delay line, then a window of the last STABLE+1 observed samples
  logic pipe0;
  logic pipe1;
  logic win[$];
  logic mout;

  logic prev_o;
  int   pulse_cnt;

  antirrebote_boton #(.STABLE_CYCLES(STABLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .button_i (button_i),
    .button_o (button_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    pipe0 = 1'b0;
    pipe1 = 1'b0;
    mout  = 1'b0;
    win.delete();
    for (int i = 0; i <= STABLE; i++) win.push_back(1'b0);
  endtask

  // Output follows once the filter has seen the same value STABLE+1 times in a row
  task automatic model_step(input logic b, input logic r);
    logic obs;
    logic same;
    if (!r) begin
      model_reset();
    end else begin
      obs   = pipe1;
      pipe1 = pipe0;
      pipe0 = b;
      win.push_back(obs);
      void'(win.pop_front());
      same = 1'b1;
      foreach (win[i]) if (win[i] != obs) same = 1'b0;
      if (same) mout = obs;
    end
  endtask

  // Drive one cycle of stimulus and queue the value button_o must hold after the next edge
  task automatic cyc(input logic b, input logic r);
    @(negedge clk);
    button_i = b;
    rst      = r;
    model_step(b, r);
    exp_q.push_back(mout);
  endtask

  // Hold a level for n cycles; hit = first cycle after which button_o equals b (0 if never)
  task automatic hold(input logic b, input int n, output int hit);
    hit = 0;
    for (int i = 1; i <= n; i++) begin
      cyc(b, 1'b1);
      @(posedge clk);
      #2;
      if (hit == 0 && button_o == b) hit = i;
    end
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (button_o !== e) begin
        failures++;
        $display("FAIL scoreboard at %0t: got %0b expected %0b", $time, button_o, e);
      end
    end
  end

  // downstream level-to-pulse converter
  always @(negedge clk) begin
    if (button_o && !prev_o) pulse_cnt++;
    prev_o = button_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hit;
    int n;
    logic lvl;
    rst       = 1'b0;
    button_i  = 1'b0;
    prev_o    = 1'b0;
    pulse_cnt = 0;
    model_reset();

    // reset held with button high
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    #1 chk("reset_level", button_o, 0);
    hold(1'b1, 12, hit);
    chk("reset_release_latency", hit, LAT);

    // clean release then clean press
    hold(1'b0, 12, hit);
    chk("clean_release_latency", hit, LAT);
    hold(1'b1, 12, hit);
    chk("clean_press_latency", hit, LAT);
    hold(1'b0, 12, hit);

    // bouncy press and bouncy release through the pulse converter
    pulse_cnt = 0;
    cyc(1'b1, 1'b1); cyc(1'b0, 1'b1); cyc(1'b1, 1'b1); cyc(1'b0, 1'b1);
    hold(1'b1, 12, hit);
    chk("bounce_press_latency", hit, LAT);
    chk("bounce_press_pulses", pulse_cnt, 1);
    pulse_cnt = 0;
    cyc(1'b0, 1'b1); cyc(1'b1, 1'b1); cyc(1'b0, 1'b1); cyc(1'b1, 1'b1);
    hold(1'b0, 12, hit);
    chk("bounce_release_latency", hit, LAT);
    chk("bounce_release_pulses", pulse_cnt, 0);

    // glitch of exactly STABLE low cycles is rejected, STABLE+1 is not
    hold(1'b1, 12, hit);
    hold(1'b0, STABLE, hit);
    chk("short_glitch_rejected", hit, 0);
    hold(1'b1, 8, hit);
    chk("short_glitch_level", hit, 1);
    hold(1'b0, 12, hit);
    chk("long_low_latency", hit, LAT);

    // reset in the middle of a count
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    #1 chk("async_reset_immediate", button_o, 0);
    cyc(1'b1, 1'b0);
    hold(1'b1, 12, hit);
    chk("midcount_reset_latency", hit, LAT);

    // randomized bursts, including glitch lengths around STABLE and occasional resets
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        n = $urandom_range(1, 2);
        for (int i = 0; i < n; i++) cyc(1'($urandom_range(0, 1)), 1'b0);
      end
      lvl = 1'($urandom_range(0, 1));
      n   = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) cyc(lvl, 1'b1);
    end

    repeat (3) @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
